fetch: RTL

//  IF stage: owns the PC, issues in-order instruction-memory requests, buffers

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_checker.sv | 22 ++
 rtl/fetch_queue.sv | 81 ++++++++
 rtl/fetch.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and types used by the fetch slice.
package riscv_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits so an address points at a whole word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_checker.sv
// Protocol assertions for the fetch stage's memory interface and queues.
module fetch_checker (
  input logic        clk,
  input logic        rst_n,
  input logic        rvalid_i,
  input logic        inflight_nz_i,
  input logic        req_i,
  input logic        gnt_i,
  input logic [31:0] addr_i,
  input logic        overflow_i
);

  a_rvalid_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
    rvalid_i |-> inflight_nz_i);

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (req_i && !gnt_i) |=> (!req_i || $stable(addr_i)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !overflow_i);

endmodule

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; used for in-flight PC tags and for the
// fetched-instruction queue. Push while full is accepted only with a same-cycle pop.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign empty_o = (count_q == {CW{1'b0}});
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state: pointer wrap, occupancy and storage write; flush wins.
  always_comb begin
    do_push_s = push_i && (!full_o || pop_i);
    do_pop_s  = pop_i && !empty_o;
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order memory
// requests, buffers responses and hands decode one instruction per cycle.
module fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = CW + 2;

  logic            started_q, started_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] tag_head_s;
  logic [CW-1:0]   tag_count_s;
  logic            tag_full_s, tag_empty_s, tag_push_s, tag_pop_s;
  fetch_entry_t    q_head_s, q_push_data_s;
  logic [CW-1:0]   q_count_s;
  logic            q_full_s, q_empty_s, q_push_s, q_pop_s;

  logic [SW-1:0]   budget_s;
  logic            fire_s, rsp_take_s, rsp_drop_s, rv_counted_s;
  logic            overflow_s;

  // Credits: every request in flight (kept or discarded) plus every queued word.
  assign budget_s     = SW'(discard_q) + SW'(tag_count_s) + SW'(q_count_s);
  assign imem_req_o   = started_q && !redirect_i && (budget_s < SW'(QDEPTH));
  assign imem_addr_o  = pc_q;
  assign fire_s       = imem_req_o && imem_gnt_i;

  // A response either retires a pre-redirect request or pairs with the oldest tag.
  assign rsp_drop_s   = imem_rvalid_i && (discard_q != {CW{1'b0}});
  assign rsp_take_s   = imem_rvalid_i && (discard_q == {CW{1'b0}}) && !tag_empty_s;
  assign rv_counted_s = rsp_drop_s || rsp_take_s;

  assign tag_push_s    = fire_s;
  assign tag_pop_s     = rsp_take_s && !redirect_i;
  assign q_pop_s       = !redirect_i && !stall_i && !q_empty_s;
  assign q_push_s      = !redirect_i && rsp_take_s && (stall_i || !q_empty_s);
  assign q_push_data_s = '{pc: tag_head_s, instr: imem_rdata_i};
  assign overflow_s    = (q_push_s && q_full_s && !q_pop_s) || (tag_push_s && tag_full_s && !tag_pop_s);

  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign instr_valid_o = valid_q;

  fetch_queue #(.W(XLEN), .DEPTH(QDEPTH)) u_tag_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_i),
    .push_i      (tag_push_s),
    .push_data_i (pc_q),
    .pop_i       (tag_pop_s),
    .head_o      (tag_head_s),
    .count_o     (tag_count_s),
    .full_o      (tag_full_s),
    .empty_o     (tag_empty_s)
  );

  fetch_queue #(.W(2 * XLEN), .DEPTH(QDEPTH)) u_instr_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_i),
    .push_i      (q_push_s),
    .push_data_i (q_push_data_s),
    .pop_i       (q_pop_s),
    .head_o      (q_head_s),
    .count_o     (q_count_s),
    .full_o      (q_full_s),
    .empty_o     (q_empty_s)
  );

  fetch_checker u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .rvalid_i      (imem_rvalid_i),
    .inflight_nz_i ((discard_q != {CW{1'b0}}) || !tag_empty_s),
    .req_i         (imem_req_o),
    .gnt_i         (imem_gnt_i),
    .addr_i        (imem_addr_o),
    .overflow_i    (overflow_s)
  );

  // Next-state for PC, discard counter and the decode-facing output registers.
  always_comb begin
    started_d = 1'b1;
    pc_d      = pc_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    if (redirect_i) begin
      // Requests still in flight become discards; one arriving now is already gone.
      pc_d      = word_align(redirect_pc_i);
      discard_d = CW'(SW'(discard_q) + SW'(tag_count_s) - SW'(rv_counted_s));
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
    end else begin
      if (fire_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (rsp_drop_s) begin
        discard_d = discard_q - CW'(1);
      end else begin
        discard_d = discard_q;
      end
      if (stall_i) begin
        valid_d = valid_q;
      end else if (!q_empty_s) begin
        instr_d  = q_head_s.instr;
        pc_out_d = q_head_s.pc;
        valid_d  = 1'b1;
      end else if (rsp_take_s) begin
        instr_d  = imem_rdata_i;
        pc_out_d = tag_head_s;
        valid_d  = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  // State registers; requests are held off until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      discard_q <= {CW{1'b0}};
      instr_q   <= NOP_INSTR;
      pc_out_q  <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      started_q <= started_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
    end
  end

endmodule
